// File: rtl/post_stream_framer_pkg.sv
// rtl/post_stream_framer_pkg.sv - shared constants and types for the post-processing stream framer
package post_stream_framer_pkg;

  localparam int MODE_LINE       = 0;
  localparam int MODE_W          = 4;

  localparam int FLOW_OVERFLOW   = 0;
  localparam int FLOW_CFG_ERR    = 1;
  localparam int FLOW_FRAME_DONE = 2;

  // control_data = {width, height, mode}; width offset depends on DIM_WIDTH
  localparam int CTRL_MODE_LSB   = 0;
  localparam int CTRL_HEIGHT_LSB = MODE_W;

  function automatic int ctrl_width_lsb(input int dim_width);
    return CTRL_HEIGHT_LSB + dim_width;
  endfunction

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

endpackage

// File: rtl/post_sync_fifo.sv
// rtl/post_sync_fifo.sv - first-word-fall-through synchronous FIFO with fill count
module post_sync_fifo #(
  parameter int WIDTH       = 24,
  parameter int DEPTH       = 16,
  parameter int DEPTH_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [DEPTH_WIDTH:0]   count
);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
    count_d = count_q + (DEPTH_WIDTH+1)'(wr_en) - (DEPTH_WIDTH+1)'(rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the head word is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/post_stream_framer.sv
// rtl/post_stream_framer.sv - buffers a pixel stream and re-emits it as sop/eop framed packets
module post_stream_framer
  import post_stream_framer_pkg::*;
#(
  parameter int BITWIDTH          = 24,
  parameter int PIX_PER_CLK       = 1,
  parameter int DIM_WIDTH         = 16,
  parameter int FIFO_DEPTH        = 16,
  parameter int DEPTH_WIDTH       = 4,
  parameter int ALMOST_FULL_DEPTH = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            control_valid,
  input  logic [2*DIM_WIDTH+3:0]          control_data,
  input  logic [BITWIDTH*PIX_PER_CLK-1:0] sink_video_data,
  input  logic                            sink_video_valid,
  output logic                            sink_video_ready,
  output logic [BITWIDTH*PIX_PER_CLK-1:0] source_data,
  output logic                            source_valid,
  output logic                            source_sop,
  output logic                            source_eop,
  input  logic                            source_ready,
  output logic [2:0]                      flow_result
);

  localparam int DATA_W    = BITWIDTH * PIX_PER_CLK;
  localparam int PPC_SHIFT = $clog2(PIX_PER_CLK);
  localparam int WIDTH_LSB = ctrl_width_lsb(DIM_WIDTH);
  localparam logic [DIM_WIDTH-1:0]   PPC_MASK = DIM_WIDTH'(PIX_PER_CLK - 1);
  localparam logic [DEPTH_WIDTH:0]   FULL_LVL = (DEPTH_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [DEPTH_WIDTH:0]   AF_LVL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_DEPTH);

  state_t                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   bpl_q, bpl_d, height_q, height_d;
  logic                   line_mode_q, line_mode_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [DIM_WIDTH-1:0]   pend_bpl_q, pend_bpl_d, pend_height_q, pend_height_d;
  logic                   pend_line_q, pend_line_d;
  logic [DIM_WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic                   ready_q, ready_d;
  logic                   overflow_q, overflow_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   done_q, done_d;

  logic [DIM_WIDTH-1:0]   in_width, in_height, in_bpl;
  logic                   in_line, in_bad, cfg_ok, cfg_bad;
  logic                   unused_mode_bits;
  logic [DATA_W-1:0]      fifo_rd_data;
  logic [DEPTH_WIDTH:0]   fifo_count, count_next;
  logic                   active, head_valid, fire, x_last, y_last, frame_last;
  logic                   wr_en, overflow_evt;

  assign in_width         = control_data[WIDTH_LSB +: DIM_WIDTH];
  assign in_height        = control_data[CTRL_HEIGHT_LSB +: DIM_WIDTH];
  assign in_line          = control_data[CTRL_MODE_LSB + MODE_LINE];
  assign unused_mode_bits = ^control_data[CTRL_MODE_LSB + 1 +: MODE_W - 1];
  assign in_bpl           = in_width >> PPC_SHIFT;
  assign in_bad           = (in_width == '0) || (in_height == '0) || ((in_width & PPC_MASK) != '0);
  assign cfg_ok           = control_valid && !in_bad;
  assign cfg_bad          = control_valid && in_bad;

  assign active       = (state_q == ST_ACTIVE);
  assign head_valid   = active && (fifo_count != '0);
  assign fire         = head_valid && source_ready;
  assign x_last       = (x_q == bpl_q - DIM_WIDTH'(1));
  assign y_last       = (y_q == height_q - DIM_WIDTH'(1));
  assign frame_last   = fire && x_last && y_last;
  // Writes are gated by true fullness, not by ready: the gap is the upstream skid slack.
  assign wr_en        = active && sink_video_valid && (fifo_count < FULL_LVL);
  assign overflow_evt = active && sink_video_valid && !(fifo_count < FULL_LVL);
  assign count_next   = fifo_count + (DEPTH_WIDTH+1)'(wr_en) - (DEPTH_WIDTH+1)'(fire);

  post_sync_fifo #(
    .WIDTH       (DATA_W),
    .DEPTH       (FIFO_DEPTH),
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (sink_video_data),
    .rd_en   (fire),
    .rd_data (fifo_rd_data),
    .count   (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    bpl_d         = bpl_q;
    height_d      = height_q;
    line_mode_d   = line_mode_q;
    pend_valid_d  = pend_valid_q;
    pend_bpl_d    = pend_bpl_q;
    pend_height_d = pend_height_q;
    pend_line_d   = pend_line_q;
    x_d           = x_q;
    y_d           = y_q;
    overflow_d    = overflow_q;
    cfg_err_d     = cfg_err_q;
    done_d        = frame_last;

    case (state_q)
      ST_IDLE: begin
        if (cfg_ok) begin
          bpl_d       = in_bpl;
          height_d    = in_height;
          line_mode_d = in_line;
          state_d     = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cfg_ok) begin
          pend_valid_d  = 1'b1;
          pend_bpl_d    = in_bpl;
          pend_height_d = in_height;
          pend_line_d   = in_line;
        end
        if (fire) begin
          if (!x_last) begin
            x_d = x_q + DIM_WIDTH'(1);
          end else begin
            x_d = '0;
            if (!y_last) begin
              y_d = y_q + DIM_WIDTH'(1);
            end else begin
              y_d = '0;
              // A config arriving on the last beat is newer than anything pending.
              if (cfg_ok) begin
                bpl_d        = in_bpl;
                height_d     = in_height;
                line_mode_d  = in_line;
                pend_valid_d = 1'b0;
              end else if (pend_valid_q) begin
                bpl_d        = pend_bpl_q;
                height_d     = pend_height_q;
                line_mode_d  = pend_line_q;
                pend_valid_d = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_ok) begin
      overflow_d = 1'b0;
      cfg_err_d  = 1'b0;
    end
    if (cfg_bad)      cfg_err_d  = 1'b1;
    if (overflow_evt) overflow_d = 1'b1;

    ready_d = (state_d == ST_ACTIVE) && (count_next < AF_LVL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bpl_q         <= '0;
      height_q      <= '0;
      line_mode_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_bpl_q    <= '0;
      pend_height_q <= '0;
      pend_line_q   <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      ready_q       <= 1'b0;
      overflow_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bpl_q         <= bpl_d;
      height_q      <= height_d;
      line_mode_q   <= line_mode_d;
      pend_valid_q  <= pend_valid_d;
      pend_bpl_q    <= pend_bpl_d;
      pend_height_q <= pend_height_d;
      pend_line_q   <= pend_line_d;
      x_q           <= x_d;
      y_q           <= y_d;
      ready_q       <= ready_d;
      overflow_q    <= overflow_d;
      cfg_err_q     <= cfg_err_d;
      done_q        <= done_d;
    end
  end

  assign sink_video_ready = ready_q;
  assign source_valid     = head_valid;
  assign source_data      = head_valid ? fifo_rd_data : '0;
  assign source_sop       = head_valid && (x_q == '0) && (line_mode_q || (y_q == '0));
  assign source_eop       = head_valid && x_last && (line_mode_q || y_last);

  assign flow_result[FLOW_OVERFLOW]   = overflow_q;
  assign flow_result[FLOW_CFG_ERR]    = cfg_err_q;
  assign flow_result[FLOW_FRAME_DONE] = done_q;

endmodule

// File: tb/tb_post_stream_framer.sv
// tb/tb_post_stream_framer.sv - directed scoreboard bench for post_stream_framer
module tb_post_stream_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        cv1, cv2;
  logic [35:0] cd1, cd2;
  logic [23:0] sd1;
  logic [47:0] sd2;
  logic        sv1, sv2, sr1, sr2;
  logic [23:0] od1;
  logic [47:0] od2;
  logic        ov1, ov2, sop1, sop2, eop1, eop2, or1, or2;
  logic [2:0]  fr1, fr2;

  post_stream_framer #(.PIX_PER_CLK(1)) dut1 (
    .clk(clk), .rst(rst), .control_valid(cv1), .control_data(cd1),
    .sink_video_data(sd1), .sink_video_valid(sv1), .sink_video_ready(sr1),
    .source_data(od1), .source_valid(ov1), .source_sop(sop1), .source_eop(eop1),
    .source_ready(or1), .flow_result(fr1)
  );

  post_stream_framer #(.PIX_PER_CLK(2)) dut2 (
    .clk(clk), .rst(rst), .control_valid(cv2), .control_data(cd2),
    .sink_video_data(sd2), .sink_video_valid(sv2), .sink_video_ready(sr2),
    .source_data(od2), .source_valid(ov2), .source_sop(sop2), .source_eop(eop2),
    .source_ready(or2), .flow_result(fr2)
  );

  typedef struct packed {
    logic [47:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int compared = 0;
  int mismatched = 0;
  int done1 = 0;
  int done2 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (fr1[2]) done1++;
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) check("dut1_unexpected_beat", 64'(od1), 64'hdead);
      else begin
        e = q1.pop_front();
        check("dut1_data", 64'(od1), 64'(e.data));
        check("dut1_sop", 64'(sop1), 64'(e.sop));
        check("dut1_eop", 64'(eop1), 64'(e.eop));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (fr2[2]) done2++;
    if (!rst && ov2 && or2) begin
      if (q2.size() == 0) check("dut2_unexpected_beat", 64'(od2), 64'hdead);
      else begin
        e = q2.pop_front();
        check("dut2_data", 64'(od2), 64'(e.data));
        check("dut2_sop", 64'(sop2), 64'(e.sop));
        check("dut2_eop", 64'(eop2), 64'(e.eop));
      end
    end
  end

  task automatic push_frame(input int which, input int bpl, input int h, input int mode, input int base);
    exp_t e;
    for (int i = 0; i < bpl * h; i++) begin
      e.data = 48'(base + i);
      e.sop  = (mode != 0) ? (i % bpl == 0) : (i == 0);
      e.eop  = (mode != 0) ? (i % bpl == bpl - 1) : (i == bpl * h - 1);
      if (which == 1) q1.push_back(e);
      else q2.push_back(e);
    end
  endtask

  task automatic cfg1(input int w, input int h, input int mode);
    cv1 = 1'b1;
    cd1 = {16'(w), 16'(h), 4'(mode)};
    @(posedge clk); #1;
    cv1 = 1'b0;
  endtask

  task automatic cfg2(input int w, input int h, input int mode);
    cv2 = 1'b1;
    cd2 = {16'(w), 16'(h), 4'(mode)};
    @(posedge clk); #1;
    cv2 = 1'b0;
  endtask

  task automatic drive1(input int base, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      sv1 = 1'b1;
      sd1 = 24'(base + first + k);
      @(posedge clk); #1;
    end
    sv1 = 1'b0;
  endtask

  task automatic drive2(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      sv2 = 1'b1;
      sd2 = 48'(base + k);
      @(posedge clk); #1;
    end
    sv2 = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk);
    check(tag, 64'(q1.size() + q2.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  initial begin
    cv1 = 0; cv2 = 0; cd1 = '0; cd2 = '0;
    sv1 = 0; sv2 = 0; sd1 = '0; sd2 = '0;
    or1 = 0; or2 = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check("reset_ready", 64'(sr1), 64'd0);
    check("reset_valid", 64'(ov1), 64'd0);
    check("reset_sop_eop", 64'({sop1, eop1}), 64'd0);
    check("reset_data", 64'(od1), 64'd0);
    check("reset_flow", 64'(fr1), 64'd0);

    // frame mode 4x2
    or1 = 1'b1;
    push_frame(1, 4, 2, 0, 'h100);
    cfg1(4, 2, 0);
    check("t1_ready_after_cfg", 64'(sr1), 64'd1);
    drive1('h100, 0, 8);
    drain("t1_drain");
    check("t1_done_pulses", 64'(done1), 64'd1);

    // line mode 4x2
    do_reset();
    push_frame(1, 4, 2, 1, 'h200);
    cfg1(4, 2, 1);
    drive1('h200, 0, 8);
    drain("t2_drain");
    check("t2_done_pulses", 64'(done1), 64'd2);

    // two pixels per beat: bad width then 6x1
    cfg2(5, 1, 0);
    check("t3_cfg_err", 64'(fr2), 64'b010);
    check("t3_idle_ready", 64'(sr2), 64'd0);
    check("t3_idle_valid", 64'(ov2), 64'd0);
    push_frame(2, 3, 1, 0, 'h300);
    cfg2(6, 1, 0);
    check("t3_err_cleared", 64'(fr2), 64'd0);
    check("t3_ready", 64'(sr2), 64'd1);
    drive2('h300, 3);
    drain("t3_drain");
    check("t3_done_pulses", 64'(done2), 64'd1);

    // backpressure, skid and overflow
    do_reset();
    or1 = 1'b0;
    push_frame(1, 4, 4, 0, 'h400);
    cfg1(4, 4, 0);
    drive1('h400, 0, 13);
    check("t4_ready_at_13", 64'(sr1), 64'd1);
    drive1('h400, 13, 1);
    check("t4_ready_at_14", 64'(sr1), 64'd0);
    drive1('h400, 14, 2);
    check("t4_no_overflow_full", 64'(fr1[0]), 64'd0);
    check("t4_head_valid_sop", 64'({ov1, sop1}), 64'b11);
    drive1('h4ff, 0, 1);
    check("t4_overflow", 64'(fr1[0]), 64'd1);
    or1 = 1'b1;
    drain("t4_drain");
    check("t4_done_pulses", 64'(done1), 64'd3);
    check("t4_ready_back", 64'(sr1), 64'd1);
    check("t4_overflow_sticky", 64'(fr1[0]), 64'd1);

    // config change mid-frame takes effect on the next frame
    do_reset();
    push_frame(1, 4, 2, 0, 'h500);
    push_frame(1, 2, 2, 0, 'h600);
    cfg1(4, 2, 0);
    drive1('h500, 0, 3);
    cfg1(2, 2, 0);
    drive1('h500, 3, 5);
    drive1('h600, 0, 4);
    drain("t5_drain");
    check("t5_done_pulses", 64'(done1), 64'd5);

    // asynchronous reset mid-frame
    do_reset();
    or1 = 1'b0;
    cfg1(4, 2, 0);
    drive1('h700, 0, 3);
    check("t6_pre_reset_valid", 64'(ov1), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(ov1), 64'd0);
    check("t6_rst_sop_eop", 64'({sop1, eop1}), 64'd0);
    check("t6_rst_data", 64'(od1), 64'd0);
    check("t6_rst_ready", 64'(sr1), 64'd0);
    check("t6_rst_flow", 64'(fr1), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_idle_ready", 64'(sr1), 64'd0);
    or1 = 1'b1;
    push_frame(1, 2, 1, 0, 'h800);
    cfg1(2, 1, 0);
    drive1('h800, 0, 2);
    drain("t6_drain");
    check("t6_done_pulses", 64'(done1), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
